nco_wave_sequencer: RTL and testbench

- Schedules the NCO waveform select (`signal_out`) from a small programmable step table.
- Each table entry is a select code plus a dwell count in clock cycles. The block steps through the entries in order, then returns the NCO to an idle select.
- Sits between the configuration/test layer and the NCO select input. Its `signal_out` drives the NCO's `signal_out` pin directly.

---
 rtl/nco_wave_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_nco_wave_sequencer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_wave_sequencer.sv
// -----------------------------------------------------------------------------
// nco_wave_sequencer
//
// Plays a small programmable step table onto the NCO waveform select. Each
// entry holds a select code and a dwell time in clock cycles. A started
// sequence drives the entries in order, holding each for max(dwell,1) cycles.
// It then pulses done for one cycle and returns the select to IDLE_SEL.
//
// Optional feature (macro NCO_SEQ_LOOP_EN):
//   Adds input loop_en, which is latched at start. When it is set, the last
//   step wraps back to entry 0 instead of finishing. The sequence then runs
//   until abort or reset.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset (table contents are kept)
//   cfg_we      table write enable, honoured only while idle
//   cfg_addr    table entry to write
//   cfg_sel     select code for the entry
//   cfg_dwell   dwell cycles for the entry (0 behaves as 1)
//   num_steps   entries to play, sampled at start, clamped to DEPTH
//   start       level-sampled start request, accepted only in IDLE
//   abort       stops a running sequence on the next edge
//   loop_en     (NCO_SEQ_LOOP_EN only) repeat the sequence until aborted
//   signal_out  select driven to the NCO
//   sel_valid   high while a table step is driven
//   step_idx    index of the current step
//   busy        high while the sequence runs
//   done        one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module nco_wave_sequencer #(
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DWELL_W  = 16,
  parameter int unsigned IDLE_SEL = 0,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned NW      = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [NW-1:0]      num_steps,
  input  logic               start,
  input  logic               abort,
`ifdef NCO_SEQ_LOOP_EN
  input  logic               loop_en,
`endif
  output logic [SEL_W-1:0]   signal_out,
  output logic               sel_valid,
  output logic [AW-1:0]      step_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  typedef struct packed {
    logic [SEL_W-1:0]   sel;
    logic [DWELL_W-1:0] dwell;
  } entry_t;

  localparam logic [SEL_W-1:0]   IDLE_CODE = SEL_W'(IDLE_SEL);
  localparam logic [NW-1:0]      DEPTH_N   = NW'(DEPTH);
  localparam logic [DWELL_W-1:0] ONE_CYC   = DWELL_W'(1);

  // A dwell of zero still shows the step for one cycle.
  function automatic logic [DWELL_W-1:0] hold_of(input entry_t e);
    return (e.dwell == '0) ? ONE_CYC : e.dwell;
  endfunction

  entry_t             tbl_q [DEPTH];

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NW-1:0]      n_q, n_d;
  logic               loop_q, loop_d;

  logic               tbl_we;
  logic               last_step;
  logic [AW-1:0]      nxt_idx;
  entry_t             nxt_entry;
  entry_t             first_entry;

  // The table is writable only while idle, so a running sequence never sees
  // its own entries change underneath it.
  assign tbl_we      = cfg_we && (state_q == ST_IDLE);

  // n is at least 1 while running, so n-1 fits in the index width.
  assign last_step   = ({1'b0, idx_q} == (n_q - NW'(1)));
  assign nxt_idx     = last_step ? '0 : (idx_q + AW'(1));
  assign nxt_entry   = tbl_q[nxt_idx];
  assign first_entry = tbl_q[0];

  // NOTE: the step table has no reset; it is plain storage that software
  // programs before use, and leaving it unreset keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_q[cfg_addr] <= {cfg_sel, cfg_dwell};
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    loop_d  = loop_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort && (num_steps != '0)) begin
          state_d = ST_RUN;
          n_d     = (num_steps > DEPTH_N) ? DEPTH_N : num_steps;
`ifdef NCO_SEQ_LOOP_EN
          loop_d  = loop_en;
`else
          loop_d  = 1'b0;
`endif
          idx_d   = '0;
          sel_d   = first_entry.sel;
          cnt_d   = hold_of(first_entry);
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          sel_d   = IDLE_CODE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q <= ONE_CYC) begin
          if (!last_step || loop_q) begin
            // Next entry (or entry 0 on a wrap) loads on this same edge,
            // so there is no gap cycle between steps.
            idx_d = nxt_idx;
            sel_d = nxt_entry.sel;
            cnt_d = hold_of(nxt_entry);
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            sel_d   = IDLE_CODE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - ONE_CYC;
        end
      end

      ST_DONE: begin
        // start and abort are both ignored here; done still pulses.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = IDLE_CODE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= IDLE_CODE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      loop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      loop_q  <= loop_d;
    end
  end

  assign signal_out = sel_q;
  assign sel_valid  = valid_q;
  assign step_idx   = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_nco_wave_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nco_wave_sequencer
//
// Directed bench for nco_wave_sequencer with default parameters. Each
// observation packs {signal_out, sel_valid, busy, done, step_idx}. It is
// compared against a hand-derived expected value. Inputs are driven and
// outputs sampled 1 time unit after each rising edge. Build with
// NCO_SEQ_LOOP_EN defined to also cover the loop feature.
// -----------------------------------------------------------------------------
module tb_nco_wave_sequencer;

  localparam int SEL_W   = 3;
  localparam int DEPTH   = 8;
  localparam int DWELL_W = 16;
  localparam int AW      = 3;
  localparam int NW      = 4;

  logic               clk       = 1'b0;
  logic               rst_n     = 1'b0;
  logic               cfg_we    = 1'b0;
  logic [AW-1:0]      cfg_addr  = '0;
  logic [SEL_W-1:0]   cfg_sel   = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic [NW-1:0]      num_steps = '0;
  logic               start     = 1'b0;
  logic               abort     = 1'b0;
`ifdef NCO_SEQ_LOOP_EN
  logic               loop_en   = 1'b0;
`endif
  logic [SEL_W-1:0]   signal_out;
  logic               sel_valid;
  logic [AW-1:0]      step_idx;
  logic               busy;
  logic               done;

  logic [8:0]         obs;
  logic [8:0]         exp_o;
  int                 vec_cnt = 0;
  int                 err_cnt = 0;

  assign obs = {signal_out, sel_valid, busy, done, step_idx};

  always #5 clk = ~clk;

  nco_wave_sequencer #(
    .SEL_W   (SEL_W),
    .DEPTH   (DEPTH),
    .DWELL_W (DWELL_W),
    .IDLE_SEL(0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_sel   (cfg_sel),
    .cfg_dwell (cfg_dwell),
    .num_steps (num_steps),
    .start     (start),
    .abort     (abort),
`ifdef NCO_SEQ_LOOP_EN
    .loop_en   (loop_en),
`endif
    .signal_out(signal_out),
    .sel_valid (sel_valid),
    .step_idx  (step_idx),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [8:0] pk(input int sel, input int v, input int b,
                                    input int d, input int idx);
    return {3'(sel), 1'(v), 1'(b), 1'(d), 3'(idx)};
  endfunction

  function automatic string show(input logic [8:0] o);
    return $sformatf("sel=%0d valid=%0b busy=%0b done=%0b idx=%0d",
                     o[8:6], o[5], o[4], o[3], o[2:0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int a, input int s, input int d);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(a);
    cfg_sel   = SEL_W'(s);
    cfg_dwell = DWELL_W'(d);
    tick();
    cfg_we    = 1'b0;
  endtask

  // Leaves the bench at the first RUN cycle.
  task automatic launch(input int n);
    num_steps = NW'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    exp_o = pk(0, 0, 0, 0, 0);
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL reset_held: got %s, want %s", show(obs), show(exp_o));
    end
    rst_n = 1'b1;
    tick();
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL reset_released: got %s, want %s", show(obs), show(exp_o));
    end
  endtask

  task automatic test_basic();
    int es [9];
    int ei [9];
    es = '{1, 1, 1, 1, 2, 2, 5, 5, 5};
    ei = '{0, 0, 0, 0, 1, 1, 2, 2, 2};
    prog(0, 1, 4);
    prog(1, 2, 2);
    prog(2, 5, 3);
    launch(3);
    for (int c = 0; c < 9; c++) begin
      exp_o = pk(es[c], 1, 1, 0, ei[c]);
      vec_cnt++;
      if (obs !== exp_o) begin
        err_cnt++;
        $display("FAIL basic[%0d]: got %s, want %s", c, show(obs), show(exp_o));
      end
      tick();
    end
    exp_o = pk(0, 0, 0, 1, 0);
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL basic_done: got %s, want %s", show(obs), show(exp_o));
    end
    tick();
    exp_o = pk(0, 0, 0, 0, 0);
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL basic_after_done: got %s, want %s", show(obs), show(exp_o));
    end
  endtask

  task automatic test_dwell_zero();
    int es [3];
    int ei [3];
    es = '{6, 7, 7};
    ei = '{0, 1, 1};
    prog(0, 6, 0);
    prog(1, 7, 2);
    launch(2);
    for (int c = 0; c < 3; c++) begin
      exp_o = pk(es[c], 1, 1, 0, ei[c]);
      vec_cnt++;
      if (obs !== exp_o) begin
        err_cnt++;
        $display("FAIL dwell0[%0d]: got %s, want %s", c, show(obs), show(exp_o));
      end
      tick();
    end
    exp_o = pk(0, 0, 0, 1, 0);
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL dwell0_done: got %s, want %s", show(obs), show(exp_o));
    end
    tick();
  endtask

  task automatic test_zero_steps();
    num_steps = '0;
    start     = 1'b1;
    exp_o     = pk(0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      vec_cnt++;
      if (obs !== exp_o) begin
        err_cnt++;
        $display("FAIL zero_steps[%0d]: got %s, want %s", c, show(obs), show(exp_o));
      end
    end
    start = 1'b0;
  endtask

  task automatic test_clamp();
    for (int i = 0; i < DEPTH; i++) prog(i, 7 - i, 1);
    launch(12);
    for (int c = 0; c < DEPTH; c++) begin
      exp_o = pk(7 - c, 1, 1, 0, c);
      vec_cnt++;
      if (obs !== exp_o) begin
        err_cnt++;
        $display("FAIL clamp[%0d]: got %s, want %s", c, show(obs), show(exp_o));
      end
      tick();
    end
    exp_o = pk(0, 0, 0, 1, 0);
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL clamp_done: got %s, want %s", show(obs), show(exp_o));
    end
    tick();
  endtask

  task automatic test_abort();
    int es [6];
    int ei [6];
    es = '{1, 1, 1, 1, 2, 2};
    ei = '{0, 0, 0, 0, 1, 1};
    prog(0, 1, 4);
    prog(1, 2, 2);
    prog(2, 5, 3);
    launch(3);
    for (int c = 0; c < 6; c++) begin
      exp_o = pk(es[c], 1, 1, 0, ei[c]);
      vec_cnt++;
      if (obs !== exp_o) begin
        err_cnt++;
        $display("FAIL abort_run[%0d]: got %s, want %s", c, show(obs), show(exp_o));
      end
      // A table write attempted mid-run must be dropped.
      if (c == 1) begin
        cfg_we    = 1'b1;
        cfg_addr  = '0;
        cfg_sel   = 3'd7;
        cfg_dwell = 16'd9;
      end
      if (c == 2) cfg_we = 1'b0;
      if (c == 5) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    exp_o = pk(0, 0, 0, 0, 0);
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL abort_stop: got %s, want %s", show(obs), show(exp_o));
    end
    tick();
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL abort_no_done: got %s, want %s", show(obs), show(exp_o));
    end
    // Entry 0 must still be {sel 1, dwell 4}.
    launch(1);
    for (int c = 0; c < 4; c++) begin
      exp_o = pk(1, 1, 1, 0, 0);
      vec_cnt++;
      if (obs !== exp_o) begin
        err_cnt++;
        $display("FAIL abort_table[%0d]: got %s, want %s", c, show(obs), show(exp_o));
      end
      tick();
    end
    exp_o = pk(0, 0, 0, 1, 0);
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL abort_table_done: got %s, want %s", show(obs), show(exp_o));
    end
    tick();
  endtask

  task automatic test_conflict();
    num_steps = NW'(1);
    start     = 1'b1;
    abort     = 1'b1;
    tick();
    exp_o = pk(0, 0, 0, 0, 0);
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL start_abort: got %s, want %s", show(obs), show(exp_o));
    end
    start = 1'b0;
    abort = 1'b0;
    tick();
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL start_abort_after: got %s, want %s", show(obs), show(exp_o));
    end
    // start held high across RUN, DONE and back into IDLE.
    start = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      exp_o = pk(1, 1, 1, 0, 0);
      vec_cnt++;
      if (obs !== exp_o) begin
        err_cnt++;
        $display("FAIL held_run[%0d]: got %s, want %s", c, show(obs), show(exp_o));
      end
      tick();
    end
    exp_o = pk(0, 0, 0, 1, 0);
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL held_done: got %s, want %s", show(obs), show(exp_o));
    end
    tick();
    exp_o = pk(0, 0, 0, 0, 0);
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL held_idle: got %s, want %s", show(obs), show(exp_o));
    end
    tick();
    exp_o = pk(1, 1, 1, 0, 0);
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL held_restart: got %s, want %s", show(obs), show(exp_o));
    end
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_o = pk(0, 0, 0, 0, 0);
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL held_abort: got %s, want %s", show(obs), show(exp_o));
    end
  endtask

  task automatic test_reset_mid_run();
    launch(3);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    exp_o = pk(0, 0, 0, 0, 0);
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL reset_mid_run: got %s, want %s", show(obs), show(exp_o));
    end
    rst_n = 1'b1;
    tick();
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL reset_mid_run_after: got %s, want %s", show(obs), show(exp_o));
    end
  endtask

`ifdef NCO_SEQ_LOOP_EN
  task automatic test_loop();
    prog(0, 3, 2);
    prog(1, 4, 1);
    loop_en = 1'b1;
    launch(2);
    loop_en = 1'b0;  // must already be latched
    for (int c = 0; c < 20; c++) begin
      exp_o = (c % 3 == 2) ? pk(4, 1, 1, 0, 1) : pk(3, 1, 1, 0, 0);
      vec_cnt++;
      if (obs !== exp_o) begin
        err_cnt++;
        $display("FAIL loop[%0d]: got %s, want %s", c, show(obs), show(exp_o));
      end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_o = pk(0, 0, 0, 0, 0);
    vec_cnt++;
    if (obs !== exp_o) begin
      err_cnt++;
      $display("FAIL loop_abort: got %s, want %s", show(obs), show(exp_o));
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_dwell_zero();
    test_zero_steps();
    test_clamp();
    test_abort();
    test_conflict();
    test_reset_mid_run();
`ifdef NCO_SEQ_LOOP_EN
    test_loop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
